// File: rtl/booth2_seq_mult.sv
// Iterative signed 32x32->64 radix-4 Booth multiplier: one Booth digit per cycle through pp.
// Latency 16 CALC cycles (fewer with EARLY_TERM); valid/ready on operands and product, DONE holds until out_ready.

module pp (
    input  logic [31:0] x_i,
    input  logic [2:0]  py_i,
    output logic [32:0] pp_o,
    output logic        e_o
);
    logic        one_w;
    logic        two_w;
    logic [32:0] mag_w;

    assign one_w = py_i[0] ^ py_i[1];
    assign two_w = (py_i == 3'b011) || (py_i == 3'b100);

    always_comb begin
        mag_w = '0;
        if (one_w)      mag_w = {x_i[31], x_i};
        else if (two_w) mag_w = {x_i, 1'b0};
    end

    // Negative digits are emitted inverted; the consumer adds py[2] at the LSB to finish the negation.
    assign pp_o = py_i[2] ? ~mag_w : mag_w;
    assign e_o  = ~pp_o[32];
endmodule

module booth2_seq_mult #(
    parameter int EARLY_TERM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] xr_q, xr_d;
    logic [32:0] yr_q, yr_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;

    logic [4:0]         sh_w;
    logic [5:0]         sh_rem_w;
    logic [2:0]         py_w;
    logic [32:0]        pp_w;
    logic               pp_e_w;
    logic [63:0]        term_w;
    logic [63:0]        inc_w;
    logic [63:0]        acc_sum_w;
    logic signed [32:0] rem_w;
    logic               rem_flat_w;

    assign sh_w     = {cnt_q, 1'b0};
    assign sh_rem_w = {1'b0, cnt_q, 1'b0} + 6'd2;
    assign py_w     = yr_q[sh_w +: 3];

    pp u_pp (
        .x_i  (xr_q),
        .py_i (py_w),
        .pp_o (pp_w),
        .e_o  (pp_e_w)
    );

    assign term_w    = {{31{pp_w[32]}}, pp_w} << sh_w;
    assign inc_w     = {63'b0, py_w[2]} << sh_w;
    assign acc_sum_w = acc_q + term_w + inc_w;

    // Remaining multiplier bits all equal to the sign means every later digit is zero.
    assign rem_w      = $signed(yr_q) >>> sh_rem_w;
    assign rem_flat_w = (rem_w == '0) || (rem_w == '1);

    always_comb begin
        state_d   = state_q;
        xr_d      = xr_q;
        yr_d      = yr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x_in;
                    yr_d    = {y_in, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum_w;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15 || (EARLY_TERM != 0 && rem_flat_w)) begin
                    state_d   = DONE;
                    product_d = acc_sum_w;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            xr_q      <= '0;
            yr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            xr_q      <= xr_d;
            yr_q      <= yr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n && state_q == CALC) assert (pp_e_w == ~pp_w[32]);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
endmodule

// File: tb/tb_booth2_seq_mult.sv
// Directed and random checks of booth2_seq_mult with EARLY_TERM=0 (dut 0) and EARLY_TERM=1 (dut 1).

module tb_booth2_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] x_in      [2];
    logic [31:0] y_in      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] product   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth2_seq_mult #(.EARLY_TERM(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x_in(x_in[0]), .y_in(y_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .product(product[0])
    );

    booth2_seq_mult #(.EARLY_TERM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x_in(x_in[1]), .y_in(y_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .product(product[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands, returns CALC cycle count until out_valid and the product (DONE left pending).
    task automatic do_op(input int sel, input logic [31:0] x, input logic [31:0] y,
                         input int gap, output int n, output logic [63:0] p);
        repeat (gap) tick();
        x_in[sel]     = x;
        y_in[sel]     = y;
        in_valid[sel] = 1'b1;
        n = 0;
        while (!in_ready[sel] && n < 40) begin tick(); n++; end
        tick();
        in_valid[sel] = 1'b0;
        x_in[sel]     = 32'hDEAD_BEEF;
        y_in[sel]     = 32'h1234_5678;
        n = 0;
        while (!out_valid[sel] && n < 40) begin tick(); n++; end
        chk("out_valid", {63'b0, out_valid[sel]}, 64'd1);
        p = product[sel];
    endtask

    task automatic release_out(input int sel, input int gap);
        repeat (gap) tick();
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        chk("idle_after_hs", {62'b0, in_ready[sel], out_valid[sel]}, 64'd2);
    endtask

    initial begin
        int          n;
        logic [63:0] p;
        logic [63:0] held;
        logic        stable;
        logic [31:0] rx, ry;
        longint      exp;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; x_in[i] = '0; y_in[i] = '0;
        end
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_in_ready", {63'b0, in_ready[0]}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid[0]}, 64'd0);
        chk("rst_product", product[0], 64'd0);

        do_op(0, 32'd3, 32'd5, 0, n, p);
        chk("lat_3x5", 64'(n), 64'd16);
        chk("prod_3x5", p, 64'd15);
        release_out(0, 0);

        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n, p);
        chk("prod_m1xm1", p, 64'h0000_0000_0000_0001);
        release_out(0, 0);

        do_op(0, 32'h8000_0000, 32'h8000_0000, 1, n, p);
        chk("prod_minxmin", p, 64'h4000_0000_0000_0000);
        release_out(0, 0);

        do_op(0, 32'h7FFF_FFFF, 32'h8000_0000, 0, n, p);
        chk("prod_maxxmin", p, 64'hC000_0000_8000_0000);

        // Product, out_valid and in_ready must hold while the consumer stalls.
        held   = product[0];
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (product[0] !== held || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) stable = 1'b0;
        end
        chk("stall_stable", {63'b0, stable}, 64'd1);
        release_out(0, 0);

        do_op(1, 32'd7, 32'd5, 0, n, p);
        chk("et_lat_y5", 64'(n), 64'd2);
        chk("et_prod_y5", p, 64'd35);
        release_out(1, 2);

        do_op(1, 32'd7, 32'hFFFF_FFFF, 0, n, p);
        chk("et_lat_ym1", 64'(n), 64'd1);
        chk("et_prod_ym1", p, 64'hFFFF_FFFF_FFFF_FFF9);
        release_out(1, 0);

        do_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 0, n, p);
        chk("et_prod_maxxmin", p, 64'hC000_0000_8000_0000);
        release_out(1, 0);

        // in_valid asserted mid-calculation must be ignored.
        x_in[0] = 32'hFFFF_FFFB; y_in[0] = 32'd9; in_valid[0] = 1'b1;
        tick();
        x_in[0] = 32'd111; y_in[0] = 32'd222;
        n = 0;
        while (!out_valid[0] && n < 40) begin tick(); n++; end
        in_valid[0] = 1'b0;
        chk("busy_ignore", product[0], 64'hFFFF_FFFF_FFFF_FFD3);
        release_out(0, 0);

        // Reset in the middle of a calculation.
        x_in[0] = 32'd1000; y_in[0] = 32'd1000; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_idle", {62'b0, in_ready[0], out_valid[0]}, 64'd2);
        chk("midrst_product", product[0], 64'd0);
        repeat (20) tick();
        chk("midrst_no_out", {63'b0, out_valid[0]}, 64'd0);
        do_op(0, 32'd2, 32'hFFFF_FFFD, 0, n, p);
        chk("after_rst_2xm3", p, 64'hFFFF_FFFF_FFFF_FFFA);
        release_out(0, 0);

        for (int i = 0; i < 1000; i++) begin
            for (int s = 0; s < 2; s++) begin
                rx  = $urandom;
                ry  = 32'($signed($urandom) >>> $urandom_range(0, 31));
                exp = longint'($signed(rx)) * longint'($signed(ry));
                do_op(s, rx, ry, $urandom_range(0, 2), n, p);
                chk(s == 0 ? "rand_et0" : "rand_et1", p, exp);
                release_out(s, $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
